memory_bram: RTL and testbench

Simple dual-port block RAM: one write port and one independent read port, both synchronous to a single clock. It is the line/frame storage primitive of the 2D-convolution datapath and holds 8-bit pixels by default. The block infers FPGA block RAM. Its read output is registered and resettable.

---
 rtl/memory_bram_pkg.sv | 14 +
 rtl/memory_bram_array.sv | 34 +++
 rtl/memory_bram.sv | 62 ++++++
 tb/tb_memory_bram.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/memory_bram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | memory_bram_pkg : shared constants and word type for the pixel BRAM    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package memory_bram_pkg;

   localparam int RAM_WIDTH_DEF  = 8;
   localparam int NB_ADDRESS_DEF = 10;

   typedef logic [RAM_WIDTH_DEF-1:0] word_t;

endpackage : memory_bram_pkg
`default_nettype wire

// File: rtl/memory_bram_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | memory_bram_array : bare inferred storage, one write port, async read  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module memory_bram_array
   import memory_bram_pkg::*;
#(
   parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
   parameter int NB_ADDRESS = NB_ADDRESS_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_wr_en,
   input  logic [NB_ADDRESS-1:0] i_wr_addr,
   input  logic [RAM_WIDTH-1:0]  i_wr_data,
   input  logic [NB_ADDRESS-1:0] i_rd_addr,
   output logic [RAM_WIDTH-1:0]  o_rd_data
);

   localparam int c_DEPTH = 2 ** NB_ADDRESS;

   logic [RAM_WIDTH-1:0] r_mem [c_DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read returns the pre-edge word; the caller's output register makes it synchronous.
   assign o_rd_data = r_mem[i_rd_addr];

endmodule : memory_bram_array
`default_nettype wire

// File: rtl/memory_bram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | memory_bram : simple dual-port RAM with reset-cleared registered read  |
// | Option: MEMORY_BRAM_WRITE_FIRST_EN selects write-first on collision.   |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module memory_bram
   import memory_bram_pkg::*;
#(
   parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
   parameter int NB_ADDRESS = NB_ADDRESS_DEF
) (
   input  logic                  i_CLK,
   input  logic                  i_reset,
   input  logic [RAM_WIDTH-1:0]  i_data,
   input  logic [NB_ADDRESS-1:0] i_writeAdd,
   input  logic [NB_ADDRESS-1:0] i_readAdd,
   input  logic                  i_wrEnable,
   output logic [RAM_WIDTH-1:0]  o_data
);

   logic                 w_wr_en;
   logic [RAM_WIDTH-1:0] w_rd_word;
   logic [RAM_WIDTH-1:0] w_next_data;
   logic [RAM_WIDTH-1:0] r_data;

   // Writes are dropped on any edge where reset is held low.
   assign w_wr_en = i_wrEnable & i_reset;

   memory_bram_array #(
      .RAM_WIDTH  (RAM_WIDTH),
      .NB_ADDRESS (NB_ADDRESS)
   ) u_array (
      .i_clk     (i_CLK),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (i_writeAdd),
      .i_wr_data (i_data),
      .i_rd_addr (i_readAdd),
      .o_rd_data (w_rd_word)
   );

`ifdef MEMORY_BRAM_WRITE_FIRST_EN
   logic w_collide;

   assign w_collide   = w_wr_en && (i_writeAdd == i_readAdd);
   assign w_next_data = w_collide ? i_data : w_rd_word;
`else
   assign w_next_data = w_rd_word;
`endif

   always_ff @(posedge i_CLK or negedge i_reset) begin
      if (!i_reset) begin
         r_data <= '0;
      end else begin
         r_data <= w_next_data;
      end
   end

   assign o_data = r_data;

endmodule : memory_bram
`default_nettype wire

// File: tb/tb_memory_bram.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | tb_memory_bram : directed + random stimulus against an array model     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_memory_bram;
   import memory_bram_pkg::*;

   localparam int c_DEPTH = 2 ** NB_ADDRESS_DEF;

   logic                      i_CLK;
   logic                      i_reset;
   logic [RAM_WIDTH_DEF-1:0]  i_data;
   logic [NB_ADDRESS_DEF-1:0] i_writeAdd;
   logic [NB_ADDRESS_DEF-1:0] i_readAdd;
   logic                      i_wrEnable;
   logic [RAM_WIDTH_DEF-1:0]  o_data;

   word_t model_mem [c_DEPTH];
   bit    model_vld [c_DEPTH];
   int    n_total;
   int    n_bad;

   memory_bram dut (
      .i_CLK      (i_CLK),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_writeAdd (i_writeAdd),
      .i_readAdd  (i_readAdd),
      .i_wrEnable (i_wrEnable),
      .o_data     (o_data)
   );

   initial i_CLK = 1'b0;
   always #2.5 i_CLK = ~i_CLK;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%02h expected=%02h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: apply inputs, predict the registered read from the model, then commit the write.
   task automatic step(input string tag, input logic rst_n, input logic we,
                       input int waddr, input word_t wd, input int raddr);
      word_t exp;
      bit    known;
      @(negedge i_CLK);
      i_reset    = rst_n;
      i_wrEnable = we;
      i_writeAdd = waddr[NB_ADDRESS_DEF-1:0];
      i_data     = wd;
      i_readAdd  = raddr[NB_ADDRESS_DEF-1:0];
      @(posedge i_CLK);
      if (!rst_n) begin
         exp   = '0;
         known = 1'b1;
`ifdef MEMORY_BRAM_WRITE_FIRST_EN
      end else if (we && waddr == raddr) begin
         exp   = wd;
         known = 1'b1;
`endif
      end else begin
         exp   = model_mem[raddr];
         known = model_vld[raddr];
      end
      if (rst_n && we) begin
         model_mem[waddr] = wd;
         model_vld[waddr] = 1'b1;
      end
      #1;
      if (known) check(tag, o_data, exp);
   endtask

   // Reset asserted between edges must clear the output without a clock edge.
   task automatic async_reset_check(input string tag);
      @(negedge i_CLK);
      i_reset = 1'b0;
      #1;
      check(tag, o_data, 8'h00);
   endtask

   function automatic int rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) return r;
      return 1016 + $urandom_range(0, 7);
   endfunction

   initial begin
      n_total    = 0;
      n_bad      = 0;
      i_reset    = 1'b0;
      i_wrEnable = 1'b0;
      i_data     = '0;
      i_writeAdd = '0;
      i_readAdd  = '0;
      for (int i = 0; i < c_DEPTH; i++) begin
         model_mem[i] = '0;
         model_vld[i] = 1'b0;
      end

      // Reset state, then a prior value that a write under reset must not disturb.
      step("reset_hold", 1'b0, 1'b0, 0, 8'h00, 0);
      step("reset_hold", 1'b0, 1'b1, 5, 8'h11, 5);
      step("seed5",      1'b1, 1'b1, 5, 8'h3C, 0);
      step("rst_wr",     1'b0, 1'b1, 5, 8'h99, 5);
      step("rst_wr",     1'b0, 1'b1, 5, 8'h99, 5);
      step("rst_rel",    1'b1, 1'b0, 0, 8'h00, 5);
      check("rst_no_wr", o_data, 8'h3C);

      // Basic and sequential write/read.
      step("wr0",   1'b1, 1'b1, 0, 8'h00, 5);
      step("rd0",   1'b1, 1'b0, 0, 8'h00, 0);
      check("basic", o_data, 8'h00);
      step("wr1",   1'b1, 1'b1, 1, 8'hFF, 0);
      step("wr2",   1'b1, 1'b1, 2, 8'h81, 0);
      step("rd1",   1'b1, 1'b0, 0, 8'h00, 1);
      check("seq1", o_data, 8'hFF);
      step("rd2",   1'b1, 1'b0, 0, 8'h00, 2);
      check("seq2", o_data, 8'h81);

      // Overwrite with the read address parked on the written word.
      step("ovw_edge", 1'b1, 1'b1, 2, 8'hE7, 2);
`ifdef MEMORY_BRAM_WRITE_FIRST_EN
      check("ovw_wf", o_data, 8'hE7);
`else
      check("ovw_rf", o_data, 8'h81);
`endif
      step("ovw_next", 1'b1, 1'b0, 0, 8'h00, 2);
      check("ovw_after", o_data, 8'hE7);

      // Address boundary, no aliasing between 1023 and 0.
      step("wr1023", 1'b1, 1'b1, 1023, 8'h5A, 1);
      step("wr0b",   1'b1, 1'b1, 0,    8'hA5, 1);
      step("rd1023", 1'b1, 1'b0, 0,    8'h00, 1023);
      check("bnd_hi", o_data, 8'h5A);
      step("rd0b",   1'b1, 1'b0, 0,    8'h00, 0);
      check("bnd_lo", o_data, 8'hA5);

      // Write disabled leaves the word untouched.
      step("wr_off", 1'b1, 1'b0, 1, 8'h33, 0);
      step("rd1b",   1'b1, 1'b0, 0, 8'h00, 1);
      check("wr_dis", o_data, 8'hFF);

      // Output is non-zero here, so an async clear is observable.
      async_reset_check("async_rst");
      step("async_hold", 1'b0, 1'b0, 0, 8'h00, 1);
      step("async_rel",  1'b1, 1'b0, 0, 8'h00, 1);
      check("async_rel_rd", o_data, 8'hFF);

      // Randomized traffic over a small address pool to provoke collisions.
      for (int n = 0; n < 3000; n++) begin
         logic  rst_n;
         logic  we;
         int    wa;
         int    ra;
         word_t wd;
         if ($urandom_range(0, 199) == 0) begin
            async_reset_check("rnd_async");
         end
         rst_n = ($urandom_range(0, 39) != 0);
         we    = $urandom_range(0, 1) == 1;
         wa    = rand_addr();
         ra    = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
         wd    = word_t'($urandom);
         step("rnd", rst_n, we, wa, wd, ra);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_memory_bram
`default_nettype wire
